// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Central stall/flush scheduler for a 5-stage pipeline
//            (FI, ID, EX, MEM, WB). Detects load-use hazards, squashes the
//            wrong-path fetch on a taken branch, holds the pipe while the
//            data memory has not acknowledged, counts stall cycles and
//            raises a sticky error on a memory timeout.
// Ports    :
//   clk, rst (sync, active-low)
//   id_rs/id_rt/id_use_rs/id_use_rt   - source operands of the ID instruction
//   ex_memrd/ex_we/ex_wa              - load/destination info of EX instruction
//   id_branch_taken                   - ID resolved a taken branch/jump
//   mem_req/mem_ack                   - MEM stage data memory handshake
//   pc_en, *_en, *_flush              - per pipeline register enable/bubble
//   state                             - RUN=0, MEMWAIT=1, ERR=2
//   err                               - sticky memory timeout flag
//   stall_cnt                         - saturating count of pc_en=0 cycles
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             ex_memrd,
   input  logic             ex_we,
   input  logic [4:0]       ex_wa,
   input  logic             id_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ack,
   output logic             pc_en,
   output logic             fi_id_en,
   output logic             fi_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_flush,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             mem_wb_flush,
   output logic [1:0]       state,
   output logic             err,
   output logic [CNT_W-1:0] stall_cnt
);

   // Wide enough to hold MEM_TIMEOUT itself.
   localparam int c_wait_w = $clog2(MEM_TIMEOUT + 1);
   localparam logic [c_wait_w-1:0] c_timeout = c_wait_w'(MEM_TIMEOUT);
   localparam logic [c_wait_w-1:0] c_wait_one = c_wait_w'(1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MEMWAIT = 2'd1,
      ST_ERR     = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [c_wait_w-1:0] wait_cnt_q, wait_cnt_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

   logic lu;
   logic mw;
   // Which output pattern the current cycle selects.
   logic hold_mem;   // memory not ready: freeze everything up to MEM
   logic freeze;     // reset or error: everything stopped, bubbles everywhere

   assign lu = ex_memrd & ex_we & (ex_wa != 5'd0) &
               ((id_use_rs & (id_rs == ex_wa)) | (id_use_rt & (id_rt == ex_wa)));
   assign mw = mem_req & ~mem_ack;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;
      hold_mem   = 1'b0;
      freeze     = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mw) begin
               hold_mem   = 1'b1;
               state_d    = ST_MEMWAIT;
               wait_cnt_d = c_wait_one;
            end
         end
         ST_MEMWAIT: begin
            if (!mem_ack) begin
               hold_mem   = 1'b1;
               wait_cnt_d = wait_cnt_q + c_wait_one;
               // Counter includes the RUN cycle that issued the access.
               if (wait_cnt_d >= c_timeout) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end
            end else begin
               // Ack arrived: fall through to the normal RUN decode below.
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end
         end
         ST_ERR: begin
            freeze = 1'b1;
         end
         default: begin
            freeze  = 1'b1;
            state_d = ST_RUN;
         end
      endcase

      if (!rst) begin
         freeze = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Output decode (no added latency): freeze > memory hold > lu > branch
   // ---------------------------------------------------------------------
   always_comb begin
      pc_en        = 1'b1;
      fi_id_en     = 1'b1;
      fi_id_flush  = 1'b0;
      id_ex_en     = 1'b1;
      id_ex_flush  = 1'b0;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      mem_wb_flush = 1'b0;

      if (freeze) begin
         pc_en        = 1'b0;
         fi_id_en     = 1'b0;
         fi_id_flush  = 1'b1;
         id_ex_en     = 1'b0;
         id_ex_flush  = 1'b1;
         ex_mem_en    = 1'b0;
         mem_wb_en    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (hold_mem) begin
         // WB keeps draining but receives a bubble while MEM is stuck.
         pc_en        = 1'b0;
         fi_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (lu) begin
         // Branch is ignored here: its operands in ID are not yet valid.
         pc_en       = 1'b0;
         fi_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end else if (id_branch_taken) begin
         fi_id_flush = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign state     = state_q;
   assign err       = err_q;
   assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire
